// File: rtl/lsu.sv
// Load/store unit: turns one CPU load/store into a single-beat bus transaction.
// It aligns and extends load data, and lane-shifts store data and byte strobes.
module lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    MemWr,
    input  logic [2:0]              MemOp,
    input  logic [DATA_WIDTH-1:0]   Addr,
    input  logic [DATA_WIDTH-1:0]   DataIn,
    output logic [DATA_WIDTH-1:0]   DataOut,
    output logic                    stall,
    output logic                    done,
    output logic                    err,
    output logic                    bus_valid,
    input  logic                    bus_ready,
    output logic [DATA_WIDTH-1:0]   bus_addr,
    output logic                    bus_wen,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    output logic [3:0]              bus_wstrb,
    input  logic                    bus_rvalid,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   addr_q, wdata_q, dout_q;
    logic [3:0]              wstrb_q;
    logic                    wen_q, err_q;
    logic [2:0]              op_q;
    logic [1:0]              off_q;

    logic                    illegal_op, misaligned, bad;
    logic [3:0]              strb_in;
    logic [DATA_WIDTH-1:0]   wdata_in, rd_shift, load_fmt;

    // Request decode, evaluated combinationally while sitting in IDLE
    always_comb begin
        illegal_op = (MemOp == 3'b011) || (MemOp == 3'b110) || (MemOp == 3'b111) ||
                     (MemWr && MemOp[2]);
        misaligned = ((MemOp[1:0] == 2'b01) && Addr[0]) ||
                     ((MemOp == 3'b010) && (Addr[1:0] != 2'b00));
        bad        = illegal_op || misaligned;
        case (MemOp[1:0])
            2'b00:   strb_in = 4'b0001 << Addr[1:0];
            2'b01:   strb_in = 4'b0011 << Addr[1:0];
            default: strb_in = 4'b1111;
        endcase
        case (MemOp[1:0])
            2'b00:   wdata_in = {4{DataIn[7:0]}};
            2'b01:   wdata_in = {2{DataIn[15:0]}};
            default: wdata_in = DataIn;
        endcase
    end

    // Load formatting from the latched size/sign and byte offset
    always_comb begin
        rd_shift = bus_rdata >> {off_q, 3'b000};
        case (op_q)
            3'b000:  load_fmt = {{(DATA_WIDTH-8){rd_shift[7]}},   rd_shift[7:0]};
            3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}},          rd_shift[7:0]};
            3'b001:  load_fmt = {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}},         rd_shift[15:0]};
            default: load_fmt = bus_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = bad ? S_DONE : S_REQ;
            S_REQ:  if (bus_ready) state_d = S_WAIT;
            S_WAIT: if (bus_rvalid) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wen_q   <= 1'b0;
            op_q    <= 3'b000;
            off_q   <= 2'b00;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid) begin
                err_q <= bad;
                if (bad) begin
                    dout_q <= '0;
                end else begin
                    addr_q  <= {Addr[DATA_WIDTH-1:2], 2'b00};
                    wdata_q <= wdata_in;
                    wstrb_q <= strb_in;
                    wen_q   <= MemWr;
                    op_q    <= MemOp;
                    off_q   <= Addr[1:0];
                end
            end
            // Stores complete on rvalid too, but leave DataOut cleared
            if (state_q == S_WAIT && bus_rvalid)
                dout_q <= wen_q ? '0 : load_fmt;
        end
    end

    assign bus_valid = (state_q == S_REQ);
    assign bus_addr  = addr_q;
    assign bus_wen   = wen_q;
    assign bus_wdata = wdata_q;
    assign bus_wstrb = wstrb_q;
    assign done      = (state_q == S_DONE);
    assign err       = done && err_q;
    assign DataOut   = dout_q;
    assign stall     = ((state_q == S_IDLE) && req_valid) ||
                       (state_q == S_REQ) || (state_q == S_WAIT);

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu against an arithmetic reference model of the access rules.
module tb_lsu;
    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, MemWr = 1'b0;
    logic [2:0]  MemOp = 3'b000;
    logic [31:0] Addr = '0, DataIn = '0;
    logic [31:0] DataOut;
    logic        stall, done, err, bus_valid, bus_wen;
    logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
    logic [3:0]  bus_wstrb;

    lsu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .MemWr(MemWr), .MemOp(MemOp),
        .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut), .stall(stall), .done(done),
        .err(err), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    logic [31:0] exp_dout = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes, 0 for an unknown code
    function automatic int unsigned acc_size(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit legal(input bit wr, input logic [2:0] op, input logic [31:0] a);
        int unsigned sz = acc_size(op);
        if (sz == 0) return 0;
        if (wr && (op == 3'b100 || op == 3'b101)) return 0;
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] m_strb(input logic [2:0] op, input logic [31:0] a);
        int unsigned sz = acc_size(op);
        if (sz == 4) return 32'hF;
        return ((32'd1 << sz) - 1) << (a % 4);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] d);
        case (acc_size(op))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        int unsigned sz = acc_size(op);
        longint v, span;
        span = longint'(64'd1 << (8 * sz));
        v = (longint'(rd) >> (8 * (a % 4))) % span;
        if (op[2] == 1'b0 && sz < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // One CPU access; entered and left on a falling edge
    task automatic access(input bit wr, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] din, input logic [31:0] rd,
                          input int rdly, input int vdly, input string tag);
        bit ok;
        int lat;
        ok = legal(wr, op, a);
        req_valid = 1'b1; MemWr = wr; MemOp = op; Addr = a; DataIn = din;
        #1 chk({tag, "_stall0"}, 32'(stall), 32'd1);
        @(negedge clk); lat = 1;
        if (!ok) begin
            exp_dout = '0;
            chk({tag, "_edone"}, 32'(done), 32'd1);
            chk({tag, "_eerr"}, 32'(err), 32'd1);
            chk({tag, "_ebv"}, 32'(bus_valid), 32'd0);
            chk({tag, "_estall"}, 32'(stall), 32'd0);
            chk({tag, "_edout"}, DataOut, exp_dout);
        end else begin
            for (int i = 0; i <= rdly; i++) begin
                chk({tag, "_bv"}, 32'(bus_valid), 32'd1);
                chk({tag, "_baddr"}, bus_addr, a & 32'hFFFF_FFFC);
                chk({tag, "_bwen"}, 32'(bus_wen), 32'(wr));
                chk({tag, "_bstrb"}, 32'(bus_wstrb), m_strb(op, a));
                if (wr) chk({tag, "_bwdata"}, bus_wdata, m_wdata(op, din));
                chk({tag, "_stallr"}, 32'(stall), 32'd1);
                if (i == rdly) bus_ready = 1'b1;
                @(negedge clk); lat++;
            end
            bus_ready = 1'b0;
            chk({tag, "_bvwait"}, 32'(bus_valid), 32'd0);
            for (int i = 0; i < vdly; i++) begin
                chk({tag, "_donew"}, 32'(done), 32'd0);
                @(negedge clk); lat++;
            end
            bus_rvalid = 1'b1; bus_rdata = rd;
            @(negedge clk); lat++;
            bus_rvalid = 1'b0;
            exp_dout = wr ? 32'd0 : m_load(op, a, rd);
            chk({tag, "_done"}, 32'(done), 32'd1);
            chk({tag, "_err"}, 32'(err), 32'd0);
            chk({tag, "_stalld"}, 32'(stall), 32'd0);
            chk({tag, "_dout"}, DataOut, exp_dout);
            chk({tag, "_lat"}, 32'(lat), 32'(3 + rdly + vdly));
        end
        // Idle cycle with a stray rvalid, which must be ignored
        req_valid = 1'b0;
        bus_rvalid = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk({tag, "_idone"}, 32'(done), 32'd0);
        chk({tag, "_ihold"}, DataOut, exp_dout);
    endtask

    initial begin
        logic [2:0] op;
        logic [31:0] a;
        @(negedge clk);
        chk("rst_bv", 32'(bus_valid), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wen", 32'(bus_wen), 32'd0);
        chk("rst_strb", 32'(bus_wstrb), 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_dout", DataOut, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0, "lb");
        chk("lb_const", DataOut, 32'hFFFF_FF80);
        access(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, $urandom, 0, 1, "sh");
        chk("sh_const", DataOut, 32'd0);
        access(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, 0, "lw_mis");
        access(1'b0, 3'b101, 32'h0000_4002, 32'h0, 32'hF00D_0000, 5, 0, "lhu");
        chk("lhu_const", DataOut, 32'h0000_F00D);

        // Reset in WAIT abandons the access; the late rvalid must not complete it
        req_valid = 1'b1; MemWr = 1'b0; MemOp = 3'b010; Addr = 32'h0000_5000;
        @(negedge clk);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0; req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mrst_bv", 32'(bus_valid), 32'd0);
        chk("mrst_addr", bus_addr, 32'd0);
        chk("mrst_wen", 32'(bus_wen), 32'd0);
        chk("mrst_strb", 32'(bus_wstrb), 32'd0);
        chk("mrst_dout", DataOut, 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_rvalid = 1'b0;
        exp_dout = '0;
        for (int i = 0; i < 3; i++) begin
            chk("post_done", 32'(done), 32'd0);
            chk("post_bv", 32'(bus_valid), 32'd0);
            chk("post_dout", DataOut, 32'd0);
            chk("post_stall", 32'(stall), 32'd0);
            @(negedge clk);
        end

        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            access(1'($urandom_range(0, 1)), op, a, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data and address width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; the state machine is held in reset while rst=0.
REQ-004 req_valid  input  1  CPU load/store request present (MemtoReg or MemWr asserted).
REQ-005 MemWr  input  1  1=store, 0=load.
REQ-006 MemOp  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes illegal.
REQ-007 Addr  input  32  byte address (ALU result).
REQ-008 DataIn  input  32  store data (rs2).
REQ-009 DataOut  output  32  load result, aligned and extended.
REQ-010 stall  output  1  CPU hold; PC and register writes frozen while 1.
REQ-011 done  output  1  one-cycle pulse: access complete, DataOut valid.
REQ-012 err  output  1  one-cycle pulse with done: misaligned or illegal MemOp.
REQ-013 bus_valid/bus_ready  output/input  1/1  request handshake.
REQ-014 bus_addr  output  32  word address, Addr with bits[1:0] forced to 00.
REQ-015 bus_wen  output  1  write request.
REQ-016 bus_wdata/bus_wstrb  output  32/4  lane-shifted store data and byte strobes.
REQ-017 bus_rvalid/bus_rdata  input  1/32  response handshake; always accepted; also terminates stores.

Function
REQ-018 FSM states IDLE, REQ, WAIT, DONE, encoded in 2 bits.
REQ-019 IDLE: if req_valid=1 and the access is legal, latch Addr, MemOp, MemWr, DataIn and go to REQ; if illegal, go to DONE with err latched; otherwise stay in IDLE.
REQ-020 Misaligned means: H/HU with Addr[0]=1, or W with Addr[1:0]!=00; illegal MemOp means codes 011, 110, 111, or a store with MemOp 100/101.
REQ-021 REQ: bus_valid=1; bus_addr, bus_wen, bus_wdata and bus_wstrb come from latched registers and stay stable until bus_ready=1; on bus_valid&bus_ready go to WAIT.
REQ-022 WAIT: on bus_rvalid=1, capture the formatted load data and go to DONE; bus_rvalid in any other state is ignored.
REQ-023 DONE: done=1 for exactly one cycle, then return to IDLE; a new req_valid is not sampled in DONE.
REQ-024 stall = req_valid in IDLE, or state in {REQ, WAIT}; stall=0 in DONE, so the CPU retires the instruction on the done cycle.
REQ-025 Strobes: B = 0001<<Addr[1:0]; H = 0011<<Addr[1:0]; W = 1111.
REQ-026 Store data: B replicates byte in all lanes; H replicates half in both halves; W passes through unchanged.
REQ-027 Load data: rdata >> (8*Addr[1:0]); B/H are sign-extended and BU/HU zero-extended from bit 7/15; W passes through.
REQ-028 Minimum legal access latency is 3 cycles from req_valid to done (bus_ready and bus_rvalid each asserted at the earliest cycle); an error access takes 1 cycle.
REQ-029 DataOut holds its last value until the next load completes; on a store or error, DataOut=0.

Reset
REQ-030 rst=0 forces, asynchronously: state=IDLE, bus_valid=0, bus_wen=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, DataOut=0, done=0, err=0.
REQ-031 Reset asserted mid-transaction (REQ/WAIT) abandons the access; a later bus_rvalid is ignored; first request is sampled on the first rising edge after rst returns to 1.

Verification
REQ-032 LB Addr=0x1003, rdata=0x80FF_1234, ready/rvalid immediate -> bus_addr=0x1000; done on cycle 3; DataOut=0xFFFF_FF80.
REQ-033 SH Addr=0x2002, DataIn=0x0000_ABCD -> bus_wstrb=1100, bus_wdata=0xABCD_ABCD, bus_wen=1; done after rvalid; DataOut=0.
REQ-034 LW Addr=0x3001 -> no bus_valid; done=1 and err=1 next cycle; stall=1 exactly one cycle.
REQ-035 LHU Addr=0x4002, bus_ready held low 5 cycles -> bus_valid and bus_addr=0x4000 stable throughout; rdata=0xF00D_0000 gives DataOut=0x0000_F00D.
REQ-036 Reset pulsed while in WAIT, then rvalid=1 -> state=IDLE, done stays 0, all outputs at reset values.
